id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode half of ID plus the ID/EX pipeline register of the 5-stage RV64I pipeline. Takes the
//  IF/ID instruction, the two operand reads returned by the register file, and the WB write port,
//  which it taps for a same-cycle WB->ID bypass. Generates the immediate and control bits,
//  detects load-use hazards (stall + bubble), and registers everything for the EX stage.
// PARAMETERS
//  XLEN        64            datapath / operand / PC width
//  CNT_W       16            width of the saturating load-use stall counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-LOW reset
//  if_pc          in   XLEN   PC of the IF/ID instruction
//  if_instr       in   32     IF/ID instruction word
//  if_valid       in   1      IF/ID holds a real instruction
//  rf_rs1         out  5      if_instr[19:15], drives register file rs1 (combinational)
//  rf_rs2         out  5      if_instr[24:20], drives register file rs2 (combinational)
//  rf_data1       in   XLEN   register file readdata1
//  rf_data2       in   XLEN   register file readdata2
//  wb_rd          in   5      WB destination (same signal as register file rd)
//  wb_data        in   XLEN   WB write data
//  wb_reg_write   in   1      WB write enable
//  flush          in   1      taken branch resolved downstream; kill the ID/EX contents
//  ex_hold        in   1      EX cannot accept; freeze ID/EX
//  stall_if       out  1      hold PC and IF/ID this cycle (combinational)
//  ex_valid       out  1      ID/EX holds a real instruction
//  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm   out XLEN   registered operands / immediate
//  ex_rs1, ex_rs2, ex_rd                     out 5      registered register indices
//  ex_funct3 out 3; ex_funct7b5 out 1; ex_alu_op out 2 (00 add, 01 branch-sub, 10 R/I funct)
//  ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  out 1
//  lu_stall_cnt   out  CNT_W  number of load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): every ex_* output, ex_valid and lu_stall_cnt go to 0. Outputs stay 0
//    until the first rising edge after reset rises. stall_if is held 0 while reset is low.
//  - Decode uses opcode = if_instr[6:0]: R 0110011, I-ALU 0010011, LD 0000011, ST 0100011,
//    BR 1100011. Any other opcode is decoded as a bubble (all controls 0, ex_valid 0).
//  - Immediates are sign-extended from bit 31 to XLEN. I: [31:20]. S: {[31:25],[11:7]}.
//    B: {[31],[7],[30:25],[11:8],1'b0}. R-type: ex_imm = 0.
//  - Bypass, per operand: if wb_reg_write && wb_rd!=0 && wb_rd==rf_rsN, use wb_data; else use
//    rf_dataN. Needed because the register file writes at the edge that ID/EX samples.
//  - Load-use: hazard = ex_valid && ex_mem_read && ex_rd!=0 && if_valid && (ex_rd==rf_rs1 ||
//    (ex_rd==rf_rs2 && opcode in {R, ST, BR})).
//  - stall_if = (hazard || ex_hold) && !flush.
//  - Per-edge priority: flush > ex_hold > hazard > load.
//    flush:  ID/EX becomes a bubble (ex_valid and all controls 0; data fields don't-care, 0 used).
//    ex_hold: all ID/EX contents unchanged.
//    hazard: insert a bubble; increment lu_stall_cnt, saturating at 2^CNT_W-1.
//    load:   capture the decoded IF/ID contents; ex_valid <= if_valid; controls are 0 if !if_valid.
//  - Latency is 1 cycle from IF/ID to ID/EX. There are no combinational paths from inputs to ex_*.
//  - x0: ex_reg_write is forced to 0 when rd==0.
// TESTING
//  1. reset=0 mid-stream, with ex_valid=1 -> all ex_* and lu_stall_cnt read 0 immediately,
//     before any clock edge.
//  2. instr addi x5,x1,-3 (0xFFD08293), rf_data1=1209 -> ex_imm=0xFFFF_FFFF_FFFF_FFFD,
//     ex_rs1_data=1209, ex_alu_src=1, ex_reg_write=1, ex_rd=5.
//  3. ld x6,0(x2) in EX; add x7,x6,x3 in IF/ID -> stall_if=1 for 1 cycle, bubble in ID/EX,
//     lu_stall_cnt 0->1; add issues on the next cycle.
//  4. WB writes x3=42 while IF/ID is add x8,x3,x3 and rf_data1=rf_data2=3522 (stale) ->
//     ex_rs1_data=ex_rs2_data=42.
//  5. flush=1 together with a hazard and ex_hold -> next cycle ex_valid=0, stall_if=0,
//     lu_stall_cnt unchanged.
//  6. CNT_W=2, five back-to-back load-use hazards -> lu_stall_cnt saturates at 3.
//     addi x0,... -> ex_reg_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID decode, WB->ID bypass, load-use detection and the ID/EX pipeline register.
// All ex_* outputs come straight from the register; stall_if is the only combinational output.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_instr,
    input  logic             if_valid,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             wb_reg_write,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall_if,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_branch,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
    } ctl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        ctl_t            ctl;
    } id_ex_t;

    id_ex_t          q;
    id_ex_t          d;
    ctl_t            ctl;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            is_r, is_i, is_ld, is_st, is_br;
    logic            known;
    logic            use_rs2;
    logic            hazard;
    logic            bubble;
    logic            load;
    logic            live;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    assign is_r  = (opcode == OP_R);
    assign is_i  = (opcode == OP_I);
    assign is_ld = (opcode == OP_LD);
    assign is_st = (opcode == OP_ST);
    assign is_br = (opcode == OP_BR);

    always_comb begin
        ctl   = '0;
        imm   = '0;
        known = 1'b0;
        unique case (1'b1)
            is_r: begin
                known         = 1'b1;
                ctl.alu_op    = 2'b10;
                ctl.reg_write = 1'b1;
            end
            is_i: begin
                known         = 1'b1;
                ctl.alu_op    = 2'b10;
                ctl.alu_src   = 1'b1;
                ctl.reg_write = 1'b1;
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            is_ld: begin
                known          = 1'b1;
                ctl.alu_src    = 1'b1;
                ctl.mem_read   = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            is_st: begin
                known         = 1'b1;
                ctl.alu_src   = 1'b1;
                ctl.mem_write = 1'b1;
                imm = {{(XLEN-12){if_instr[31]}},
                       if_instr[31:25], if_instr[11:7]};
            end
            is_br: begin
                known      = 1'b1;
                ctl.alu_op = 2'b01;
                ctl.branch = 1'b1;
                imm = {{(XLEN-13){if_instr[31]}}, if_instr[31],
                       if_instr[7], if_instr[30:25],
                       if_instr[11:8], 1'b0};
            end
            default: ;
        endcase
        if (rd == 5'd0) ctl.reg_write = 1'b0;
    end

    assign use_rs2 = is_r | is_st | is_br;
    assign live    = if_valid & known;

    // Register file writes on the same edge we sample, so WB data wins here.
    always_comb begin
        d          = '0;
        d.valid    = live;
        d.pc       = if_pc;
        d.rs1_data = (wb_reg_write && wb_rd != 5'd0 && wb_rd == rf_rs1)
                     ? wb_data : rf_data1;
        d.rs2_data = (wb_reg_write && wb_rd != 5'd0 && wb_rd == rf_rs2)
                     ? wb_data : rf_data2;
        d.imm      = imm;
        d.rs1      = rf_rs1;
        d.rs2      = rf_rs2;
        d.rd       = rd;
        d.funct3   = if_instr[14:12];
        d.funct7b5 = if_instr[30];
        d.ctl      = live ? ctl : '0;
    end

    assign hazard = q.valid && q.ctl.mem_read && q.rd != 5'd0 && if_valid &&
                    (q.rd == rf_rs1 || (q.rd == rf_rs2 && use_rs2));

    assign bubble   = flush || (!ex_hold && hazard);
    assign load     = !flush && !ex_hold && !hazard;
    assign stall_if = reset && (hazard || ex_hold) && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_stall_cnt <= '0;
        end else if (!flush && !ex_hold && hazard &&
                     lu_stall_cnt != {CNT_W{1'b1}}) begin
            lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_valid      = q.valid;
    assign ex_pc         = q.pc;
    assign ex_rs1_data   = q.rs1_data;
    assign ex_rs2_data   = q.rs2_data;
    assign ex_imm        = q.imm;
    assign ex_rs1        = q.rs1;
    assign ex_rs2        = q.rs2;
    assign ex_rd         = q.rd;
    assign ex_funct3     = q.funct3;
    assign ex_funct7b5   = q.funct7b5;
    assign ex_alu_op     = q.ctl.alu_op;
    assign ex_alu_src    = q.ctl.alu_src;
    assign ex_mem_read   = q.ctl.mem_read;
    assign ex_mem_write  = q.ctl.mem_write;
    assign ex_mem_to_reg = q.ctl.mem_to_reg;
    assign ex_reg_write  = q.ctl.reg_write;
    assign ex_branch     = q.ctl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a reference model.
// A second instance with a 2-bit stall counter shares all inputs to exercise saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [63:0] rf_data1, rf_data2;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_reg_write, flush, ex_hold;
    logic        stall_if, ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [15:0] lu_stall_cnt;

    logic [4:0]  b_rf_rs1, b_rf_rs2;
    logic        b_stall_if, b_ex_valid;
    logic [63:0] b_ex_pc, b_ex_rs1_data, b_ex_rs2_data, b_ex_imm;
    logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
    logic [2:0]  b_ex_funct3;
    logic        b_ex_funct7b5;
    logic [1:0]  b_ex_alu_op;
    logic        b_ex_alu_src, b_ex_mem_read, b_ex_mem_write;
    logic        b_ex_mem_to_reg, b_ex_reg_write, b_ex_branch;
    logic [1:0]  b_lu_stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
        .if_valid(if_valid), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_write(wb_reg_write), .flush(flush),
        .ex_hold(ex_hold), .stall_if(stall_if), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_branch(ex_branch), .lu_stall_cnt(lu_stall_cnt)
    );

    id_ex_stage #(.XLEN(64), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
        .if_valid(if_valid), .rf_rs1(b_rf_rs1), .rf_rs2(b_rf_rs2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_write(wb_reg_write), .flush(flush),
        .ex_hold(ex_hold), .stall_if(b_stall_if), .ex_valid(b_ex_valid),
        .ex_pc(b_ex_pc), .ex_rs1_data(b_ex_rs1_data),
        .ex_rs2_data(b_ex_rs2_data), .ex_imm(b_ex_imm), .ex_rs1(b_ex_rs1),
        .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd), .ex_funct3(b_ex_funct3),
        .ex_funct7b5(b_ex_funct7b5), .ex_alu_op(b_ex_alu_op),
        .ex_alu_src(b_ex_alu_src), .ex_mem_read(b_ex_mem_read),
        .ex_mem_write(b_ex_mem_write), .ex_mem_to_reg(b_ex_mem_to_reg),
        .ex_reg_write(b_ex_reg_write), .ex_branch(b_ex_branch),
        .lu_stall_cnt(b_lu_stall_cnt)
    );

    typedef struct {
        bit              valid;
        longint unsigned pc, d1, d2, imm;
        int              rs1, rs2, rd, f3, f7, aluop;
        bit              src, mr, mw, m2r, rw, br;
    } exp_t;

    exp_t m;
    int   cnt16, cnt2;
    int   vectors = 0;
    int   miscompares = 0;
    bit   seen_stall;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 unknown, 1 R, 2 I-ALU, 3 load, 4 store, 5 branch
    function automatic int kind_of(input logic [31:0] i);
        case (i[6:0])
            7'h33:   return 1;
            7'h13:   return 2;
            7'h03:   return 3;
            7'h23:   return 4;
            7'h63:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic longint imm_of(input logic [31:0] i);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        longint v;
        v = 0;
        case (kind_of(i))
            2, 3: begin s12 = i[31:20]; v = s12; end
            4: begin s12 = {i[31:25], i[11:7]}; v = s12; end
            5: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13; end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic longint unsigned opnd(input int rs, input logic [63:0] rf);
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return wb_data;
        return rf;
    endfunction

    function automatic bit model_hazard();
        int k, a, b;
        k = kind_of(if_instr);
        a = if_instr[19:15];
        b = if_instr[24:20];
        return m.valid && m.mr && m.rd != 0 && if_valid &&
               (m.rd == a || (m.rd == b && (k == 1 || k == 4 || k == 5)));
    endfunction

    task automatic model_advance();
        exp_t n;
        int   k;
        n = '{default: 0};
        if (flush) begin
            m = n;
        end else if (ex_hold) begin
        end else if (model_hazard()) begin
            m = n;
            cnt16 = (cnt16 < 65535) ? cnt16 + 1 : 65535;
            cnt2  = (cnt2 < 3) ? cnt2 + 1 : 3;
        end else begin
            k = kind_of(if_instr);
            n.valid = if_valid && k != 0;
            n.pc  = if_pc;
            n.rs1 = if_instr[19:15];
            n.rs2 = if_instr[24:20];
            n.rd  = if_instr[11:7];
            n.f3  = if_instr[14:12];
            n.f7  = if_instr[30];
            n.d1  = opnd(n.rs1, rf_data1);
            n.d2  = opnd(n.rs2, rf_data2);
            n.imm = imm_of(if_instr);
            if (n.valid) begin
                n.aluop = (k == 1 || k == 2) ? 2 : (k == 5) ? 1 : 0;
                n.src   = (k == 2 || k == 3 || k == 4);
                n.mr    = (k == 3);
                n.m2r   = (k == 3);
                n.mw    = (k == 4);
                n.br    = (k == 5);
                n.rw    = (k <= 3) && n.rd != 0;
            end
            m = n;
        end
    endtask

    task automatic check_all();
        check("ex_valid", ex_valid, m.valid);
        check("ex_alu_op", ex_alu_op, m.aluop);
        check("ex_alu_src", ex_alu_src, m.src);
        check("ex_mem_read", ex_mem_read, m.mr);
        check("ex_mem_write", ex_mem_write, m.mw);
        check("ex_mem_to_reg", ex_mem_to_reg, m.m2r);
        check("ex_reg_write", ex_reg_write, m.rw);
        check("ex_branch", ex_branch, m.br);
        check("lu_stall_cnt", lu_stall_cnt, cnt16);
        check("sat_cnt", b_lu_stall_cnt, cnt2);
        check("sat_valid", b_ex_valid, m.valid);
        if (m.valid) begin
            check("ex_pc", ex_pc, m.pc);
            check("ex_rs1_data", ex_rs1_data, m.d1);
            check("ex_rs2_data", ex_rs2_data, m.d2);
            check("ex_imm", ex_imm, m.imm);
            check("ex_rs1", ex_rs1, m.rs1);
            check("ex_rs2", ex_rs2, m.rs2);
            check("ex_rd", ex_rd, m.rd);
            check("ex_funct3", ex_funct3, m.f3);
            check("ex_funct7b5", ex_funct7b5, m.f7);
        end
    endtask

    task automatic step(input logic [31:0] instr, input logic iv,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [4:0] wrd, input logic [63:0] wd,
                        input logic we, input logic fl, input logic hd);
        bit es;
        @(negedge clk);
        if_instr = instr; if_valid = iv; if_pc = if_pc + 64'd4;
        rf_data1 = d1; rf_data2 = d2;
        wb_rd = wrd; wb_data = wd; wb_reg_write = we;
        flush = fl; ex_hold = hd;
        #1;
        es = (model_hazard() || hd) && !fl;
        seen_stall = stall_if;
        check("stall_if", stall_if, es);
        check("sat_stall_if", b_stall_if, es);
        check("rf_rs1", rf_rs1, instr[19:15]);
        check("rf_rs2", rf_rs2, instr[24:20]);
        model_advance();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic simple(input logic [31:0] instr, input logic [63:0] d1);
        step(instr, 1'b1, d1, 64'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] ADDI5  = 32'hFFD08293;
    localparam logic [31:0] LD6    = 32'h00013303;
    localparam logic [31:0] ADD7   = 32'h003303B3;
    localparam logic [31:0] ADD8   = 32'h00318433;
    localparam logic [31:0] ADDIX0 = 32'h00508013;

    initial begin
        logic [6:0]  ops [0:5];
        logic [31:0] ri;
        int          prev;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h73;
        m = '{default: 0};
        cnt16 = 0; cnt2 = 0;
        reset = 1'b0; if_pc = 64'h1000; if_instr = 32'h0; if_valid = 1'b0;
        rf_data1 = '0; rf_data2 = '0; wb_rd = '0; wb_data = '0;
        wb_reg_write = 1'b0; flush = 1'b0; ex_hold = 1'b1;
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_cnt", lu_stall_cnt, 0);
        check("rst_stall_if", stall_if, 0);
        @(negedge clk);
        reset = 1'b1; ex_hold = 1'b0;

        simple(ADDI5, 64'd1209);
        check("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFD);
        check("addi_rs1_data", ex_rs1_data, 64'd1209);
        check("addi_alu_src", ex_alu_src, 1);
        check("addi_reg_write", ex_reg_write, 1);
        check("addi_rd", ex_rd, 5);

        simple(LD6, 64'd100);
        simple(ADD7, 64'd7);
        check("lu_stall_seen", seen_stall, 1);
        check("lu_bubble", ex_valid, 0);
        check("lu_cnt_one", lu_stall_cnt, 1);
        simple(ADD7, 64'd7);
        check("lu_issue_stall", seen_stall, 0);
        check("lu_issue_rd", ex_rd, 7);
        check("lu_issue_valid", ex_valid, 1);

        step(ADD8, 1'b1, 64'd3522, 64'd3522, 5'd3, 64'd42, 1'b1, 1'b0, 1'b0);
        check("byp_rs1", ex_rs1_data, 64'd42);
        check("byp_rs2", ex_rs2_data, 64'd42);

        simple(LD6, 64'd0);
        prev = cnt16;
        step(ADD7, 1'b1, 64'd0, 64'd0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
        check("flush_stall", seen_stall, 0);
        check("flush_valid", ex_valid, 0);
        check("flush_cnt", lu_stall_cnt, prev);
        simple(ADD7, 64'd0);
        check("after_flush_stall", seen_stall, 0);

        for (int i = 0; i < 5; i++) begin
            simple(LD6, 64'd0);
            simple(ADD7, 64'd0);
        end
        check("sat_at_3", b_lu_stall_cnt, 3);

        simple(ADDIX0, 64'd5);
        check("x0_reg_write", ex_reg_write, 0);
        check("x0_valid", ex_valid, 1);

        for (int i = 0; i < 600; i++) begin
            int k;
            k = $urandom_range(0, 5);
            ri = $urandom;
            ri[6:0]   = ops[k];
            ri[11:7]  = 5'($urandom_range(0, 7));
            ri[19:15] = 5'($urandom_range(0, 7));
            ri[24:20] = 5'($urandom_range(0, 7));
            step(ri, ($urandom_range(0, 7) != 0),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
        end

        simple(ADDI5, 64'd1);
        simple(ADDI5, 64'd1);
        check("pre_rst_valid", ex_valid, 1);
        @(posedge clk);
        #2;
        ex_hold = 1'b1;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", ex_valid, 0);
        check("mid_rst_imm", ex_imm, 0);
        check("mid_rst_pc", ex_pc, 0);
        check("mid_rst_rd", ex_rd, 0);
        check("mid_rst_rw", ex_reg_write, 0);
        check("mid_rst_alu_src", ex_alu_src, 0);
        check("mid_rst_cnt", lu_stall_cnt, 0);
        check("mid_rst_sat_cnt", b_lu_stall_cnt, 0);
        check("mid_rst_stall_if", stall_if, 0);
        @(negedge clk);
        reset = 1'b1;
        m = '{default: 0};
        cnt16 = 0; cnt2 = 0;
        simple(ADDI5, 64'd1209);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
